spi_master_core: RTL and testbench



---
 rtl/spi_master_core_if.sv | 25 ++
 rtl/spi_master_core.sv | 183 ++++++++++++++++++
 tb/tb_spi_master_core.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_master_core_if.sv
// Register-side request bus plus SPI pins for spi_master_core.
// The master modport is the requester (and, in a bench, the slave model driving miso).
interface spi_master_core_if;
   logic [9:0] freq;
   logic       start_w;
   logic       start_r;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       done;
   logic       ss;
   logic       sck;
   logic       mosi;
   logic       miso;

   modport master (
      output freq, start_w, start_r, addr, wdata, miso,
      input  rdata, done, ss, sck, mosi
   );

   modport slave (
      input  freq, start_w, start_r, addr, wdata, miso,
      output rdata, done, ss, sck, mosi
   );
endinterface

// File: rtl/spi_master_core.sv
// SPI mode-0 master running one 16-bit command+data frame per request edge.
// Optional SPI_MASTER_MISO_SYNC_EN adds a 2-flop synchronizer on miso.
module spi_master_core (
   input logic               clk,
   input logic               rst,
   spi_master_core_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [9:0]  cnt_r, cnt_s;
   logic [9:0]  h_r, h_s;
   logic [3:0]  bit_r, bit_s;
   logic [15:0] frame_r, frame_s;
   logic [7:0]  rx_r, rx_s;
   logic        rw_r, rw_s;
   logic        start_w_r, start_r_r;
   logic        ss_r, ss_s;
   logic        sck_r, sck_s;
   logic        mosi_r, mosi_s;
   logic        done_r, done_s;
   logic [7:0]  rdata_r, rdata_s;
   logic        req_w_s, req_r_s, tick_s, miso_smp_s;
   logic [9:0]  freq_clamp_s;
   logic [7:0]  cmd_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
   logic miso_meta_r, miso_sync_r;

   // Two-stage synchronizer for the asynchronous slave data line
   always_ff @(posedge clk) begin
      if (rst) begin
         miso_meta_r <= 1'b0;
         miso_sync_r <= 1'b0;
      end else begin
         miso_meta_r <= bus.miso;
         miso_sync_r <= miso_meta_r;
      end
   end
   assign miso_smp_s = miso_sync_r;
`else
   assign miso_smp_s = bus.miso;
`endif

   assign req_w_s      = bus.start_w & ~start_w_r;
   assign req_r_s      = bus.start_r & ~start_r_r & ~req_w_s;
   assign freq_clamp_s = (bus.freq == 10'd0) ? 10'd1 : bus.freq;
   assign cmd_s        = {~req_w_s, bus.addr[6:0]};
   assign tick_s       = (cnt_r == 10'd0);

   // Next-state and next-output logic for the frame sequencer
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      h_s     = h_r;
      bit_s   = bit_r;
      frame_s = frame_r;
      rx_s    = rx_r;
      rw_s    = rw_r;
      ss_s    = ss_r;
      sck_s   = sck_r;
      mosi_s  = mosi_r;
      done_s  = 1'b0;
      rdata_s = rdata_r;
      case (state_r)
         IDLE: begin
            // the done cycle itself still counts as busy
            if ((req_w_s || req_r_s) && !done_r) begin
               state_s = SETUP;
               rw_s    = ~req_w_s;
               h_s     = freq_clamp_s;
               cnt_s   = freq_clamp_s - 10'd1;
               frame_s = {cmd_s, (req_w_s ? bus.wdata : 8'h00)};
               ss_s    = 1'b0;
               sck_s   = 1'b0;
               mosi_s  = cmd_s[7];
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            if (tick_s) begin
               state_s = SHIFT;
               cnt_s   = h_r - 10'd1;
               sck_s   = 1'b1;
               bit_s   = 4'd0;
               rx_s    = {rx_r[6:0], miso_smp_s};
            end else begin
               cnt_s = cnt_r - 10'd1;
            end
         end
         SHIFT: begin
            if (tick_s) begin
               cnt_s = h_r - 10'd1;
               if (sck_r) begin
                  sck_s = 1'b0;
                  if (bit_r != 4'd15) begin
                     frame_s = {frame_r[14:0], 1'b0};
                     mosi_s  = frame_r[14];
                  end else begin
                     mosi_s = mosi_r;
                  end
               end else if (bit_r == 4'd15) begin
                  state_s = HOLD;
               end else begin
                  sck_s = 1'b1;
                  bit_s = bit_r + 4'd1;
                  rx_s  = {rx_r[6:0], miso_smp_s};
               end
            end else begin
               cnt_s = cnt_r - 10'd1;
            end
         end
         HOLD: begin
            if (tick_s) begin
               state_s = IDLE;
               ss_s    = 1'b1;
               mosi_s  = 1'b0;
               done_s  = 1'b1;
               if (rw_r) begin
                  rdata_s = rx_r;
               end else begin
                  rdata_s = rdata_r;
               end
            end else begin
               cnt_s = cnt_r - 10'd1;
            end
         end
         default: begin
            state_s = IDLE;
            ss_s    = 1'b1;
            sck_s   = 1'b0;
            mosi_s  = 1'b0;
         end
      endcase
   end

   // State, datapath and registered-output flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= 10'd0;
         h_r       <= 10'd1;
         bit_r     <= 4'd0;
         frame_r   <= 16'h0000;
         rx_r      <= 8'h00;
         rw_r      <= 1'b0;
         start_w_r <= 1'b0;
         start_r_r <= 1'b0;
         ss_r      <= 1'b1;
         sck_r     <= 1'b0;
         mosi_r    <= 1'b0;
         done_r    <= 1'b0;
         rdata_r   <= 8'h00;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         h_r       <= h_s;
         bit_r     <= bit_s;
         frame_r   <= frame_s;
         rx_r      <= rx_s;
         rw_r      <= rw_s;
         start_w_r <= bus.start_w;
         start_r_r <= bus.start_r;
         ss_r      <= ss_s;
         sck_r     <= sck_s;
         mosi_r    <= mosi_s;
         done_r    <= done_s;
         rdata_r   <= rdata_s;
      end
   end

   assign bus.ss    = ss_r;
   assign bus.sck   = sck_r;
   assign bus.mosi  = mosi_r;
   assign bus.done  = done_r;
   assign bus.rdata = rdata_r;
endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: frame contents, SCK timing, rdata capture,
// request filtering and mid-frame reset.
module tb_spi_master_core;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   spi_master_core_if bus ();

   spi_master_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request, act as the SPI slave, and check the complete frame.
   task automatic run_frame(input logic sw, input logic sr, input logic [7:0] a,
                            input logic [7:0] d, input logic [9:0] f, input logic [7:0] slv,
                            input logic mid_r, input int h, input logic [15:0] exp_mosi,
                            input logic [7:0] exp_rd);
      int ss_first = -1;
      int rise1 = -1;
      int rise2 = -1;
      int rises = 0;
      int falls = 0;
      int done_at = -1;
      int done_cnt = 0;
      int ss_low = 0;
      logic prev_sck = 1'b0;
      logic [15:0] cap = 16'h0000;
      logic [15:0] stx;
      stx = {8'h00, slv};
      @(negedge clk);
      bus.addr = a; bus.wdata = d; bus.freq = f;
      bus.start_w = sw; bus.start_r = sr;
      for (int cyc = 1; cyc <= 34 * h + 40; cyc++) begin
         @(negedge clk);
         if (cyc == 3) begin bus.start_w = 1'b0; bus.start_r = 1'b0; end
         if (cyc == 5) begin bus.addr = ~a; bus.wdata = ~d; bus.freq = f + 10'd7; end
         if (mid_r && cyc == 8)  bus.start_r = 1'b1;
         if (mid_r && cyc == 10) bus.start_r = 1'b0;
         if (!bus.ss) begin
            ss_low++;
            if (ss_first < 0) ss_first = cyc;
         end
         if (bus.sck && !prev_sck) begin
            rises++;
            cap = {cap[14:0], bus.mosi};
            if (rises == 1) rise1 = cyc;
            if (rises == 2) rise2 = cyc;
         end
         if (!bus.sck && prev_sck) falls++;
         prev_sck = bus.sck;
         bus.miso = (!bus.ss && falls < 16) ? stx[15 - falls] : 1'b0;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = cyc;
               chk("ss_at_done", {31'd0, bus.ss}, 32'd1);
               chk("mosi_at_done", {31'd0, bus.mosi}, 32'd0);
               chk("rdata_at_done", {24'd0, bus.rdata}, {24'd0, exp_rd});
            end
         end
         if (done_at >= 0 && cyc >= done_at + 3) break;
      end
      chk("done_seen", (done_at >= 0) ? 32'd1 : 32'd0, 32'd1);
      chk("ss_first", ss_first, 32'd1);
      chk("mosi_bits", {16'd0, cap}, {16'd0, exp_mosi});
      chk("sck_rises", rises, 32'd16);
      chk("first_rise", rise1 - ss_first, h);
      chk("sck_period", rise2 - rise1, 2 * h);
      chk("ss_low_time", ss_low, 34 * h);
      chk("done_time", done_at - ss_first, 34 * h);
      chk("done_pulses", done_cnt, 32'd1);
      chk("rdata_after", {24'd0, bus.rdata}, {24'd0, exp_rd});
   endtask

   // Start a write, hit reset at SCK pulse 5, confirm a clean abort.
   task automatic reset_mid_frame();
      int rises = 0;
      int dones = 0;
      logic prev_sck = 1'b0;
      @(negedge clk);
      bus.addr = 8'h33; bus.wdata = 8'h99; bus.freq = 10'd4; bus.start_w = 1'b1;
      for (int cyc = 1; cyc <= 400 && rises < 5; cyc++) begin
         @(negedge clk);
         if (cyc == 3) bus.start_w = 1'b0;
         if (bus.sck && !prev_sck) rises++;
         prev_sck = bus.sck;
      end
      chk("rst_reached_pulse5", rises, 32'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ss", {31'd0, bus.ss}, 32'd1);
      chk("rst_sck", {31'd0, bus.sck}, 32'd0);
      chk("rst_mosi", {31'd0, bus.mosi}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
      rst = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("rst_no_done", dones, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.freq = 10'd1; bus.start_w = 1'b0; bus.start_r = 1'b0;
      bus.addr = 8'h00; bus.wdata = 8'h00; bus.miso = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ss", {31'd0, bus.ss}, 32'd1);
      chk("reset_sck", {31'd0, bus.sck}, 32'd0);
      chk("reset_mosi", {31'd0, bus.mosi}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_rdata", {24'd0, bus.rdata}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // sw sr addr   wdata  freq    slave  mid h    mosi      rdata
      run_frame(1'b1, 1'b0, 8'h55, 8'hAA, 10'd100, 8'h00, 1'b0, 100, 16'h55AA, 8'h00);
      run_frame(1'b0, 1'b1, 8'h55, 8'hAA, 10'd100, 8'h00, 1'b0, 100, 16'hD500, 8'h00);
      run_frame(1'b0, 1'b1, 8'h55, 8'h00, 10'd3,   8'h3C, 1'b0, 3,   16'hD500, 8'h3C);
      run_frame(1'b1, 1'b0, 8'h81, 8'h5A, 10'd1,   8'hFF, 1'b0, 1,   16'h015A, 8'h3C);
      run_frame(1'b1, 1'b0, 8'h7F, 8'hC3, 10'd0,   8'hFF, 1'b0, 1,   16'h7FC3, 8'h3C);
      run_frame(1'b1, 1'b1, 8'h12, 8'h34, 10'd2,   8'hFF, 1'b0, 2,   16'h1234, 8'h3C);
      run_frame(1'b1, 1'b0, 8'h23, 8'h45, 10'd2,   8'hFF, 1'b1, 2,   16'h2345, 8'h3C);
      reset_mid_frame();
      run_frame(1'b0, 1'b1, 8'h0A, 8'h77, 10'd5,   8'hA5, 1'b0, 5,   16'h8A00, 8'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
